// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the 1024-point radix-4
// in-place FFT sequencing controller.
package fft_pkg;

  localparam int FFT_N      = 1024;
  localparam int FFT_STAGES = 5;
  localparam int BANK_DEPTH = 256;
  localparam int CNT_W      = 11;

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_COMP = 2'b01;
  localparam logic [1:0] MODE_OUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMP,
    ST_DRAIN,
    ST_OUT
  } fft_state_e;

  function automatic logic [3:0] bank_sel(
    input logic [1:0] b
  );
    bank_sel = 4'b0001 << b;
  endfunction

endpackage

// File: rtl/fft_ctrl_dly_line.sv
// dly_line: WIDTH x DEPTH shift register with async active-low clear.
// DEPTH=0 degenerates to a wire.
module dly_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          sr[i] <= '0;
        end
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: load / five-stage compute / output sequencer for the
// 1024-point radix-4 FFT, with a LAT-delayed write-back copy.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       ld_we,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       mode,
  output logic             bf_valid,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [1:0]       wr_mode,
  output logic             wr_en,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int LAT = RD_LAT + BF_LAT;
  localparam logic [7:0] DR_LAST = 8'(LAT - 1);
  localparam logic [7:0] BK_LAST = 8'(BANK_DEPTH - 1);
  localparam logic [9:0] N_LAST = 10'(FFT_N - 1);
  localparam logic [2:0] STG_LAST = 3'(FFT_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_ST1 = CNT_W'(FFT_N);
  localparam logic [CNT_W-1:0] CNT_OLAST =
    CNT_W'(BANK_DEPTH - 1);

  fft_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       stg_q, stg_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             bf_q;
  logic             rdy_q;
  logic             busy_q;
  logic             acc;

  assign acc = in_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (acc) begin
          if (cnt_q[9:0] == N_LAST) begin
            cnt_d   = CNT_ST1;
            stg_d   = '0;
            state_d = ST_COMP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_COMP: begin
        if (cnt_q[7:0] == BK_LAST) begin
          dcnt_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DR_LAST) begin
          if (stg_q == STG_LAST) begin
            cnt_d   = '0;
            state_d = ST_OUT;
          end else begin
            // ST5 lands on 0x000 by natural 11-bit wrap
            stg_d   = stg_q + 3'd1;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_COMP;
          end
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      ST_OUT: begin
        if (cnt_q[7:0] == BK_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_d = MODE_LOAD;
    unique case (state_d)
      ST_COMP, ST_DRAIN: mode_d = MODE_COMP;
      ST_OUT:            mode_d = MODE_OUT;
      default:           mode_d = MODE_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stg_q   <= '0;
      dcnt_q  <= '0;
      mode_q  <= MODE_LOAD;
      bf_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      dcnt_q  <= dcnt_d;
      mode_q  <= mode_d;
      bf_q    <= (state_d == ST_COMP);
      rdy_q   <= (state_d == ST_IDLE) ||
                 (state_d == ST_LOAD);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign in_ready = rdy_q;
  assign ld_we    = acc ? bank_sel(cnt_q[9:8]) : 4'b0000;
  assign cnt      = cnt_q;
  assign mode     = mode_q;
  assign bf_valid = bf_q;
  assign busy     = busy_q;

  dly_line #(
    .WIDTH (CNT_W + 3),
    .DEPTH (LAT)
  ) u_wb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({cnt_q, mode_q, bf_q}),
    .q     ({wr_cnt, wr_mode, wr_en})
  );

  logic is_out;
  logic is_last;

  assign is_out  = (state_q == ST_OUT);
  assign is_last = is_out && (cnt_q == CNT_OLAST);

  dly_line #(
    .WIDTH (2),
    .DEPTH (RD_LAT)
  ) u_out (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({is_out, is_last}),
    .q     ({out_valid, out_last})
  );

  assign done = out_last;

endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: scoreboard bench driving two controllers in lockstep,
// default latencies and RD_LAT=2/BF_LAT=0.
module tb_fft_ctrl;

  typedef struct packed {
    logic [3:0]  we;
    logic [10:0] cnt;
    logic [1:0]  mode;
    logic [31:0] cyc;
  } ev_t;

  localparam int Q_LD = 0;
  localparam int Q_RD = 1;
  localparam int Q_WR = 2;
  localparam int Q_OR = 3;
  localparam int Q_OV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;

  logic        in_ready_w [2];
  logic [3:0]  ld_we_w    [2];
  logic [10:0] cnt_w      [2];
  logic [1:0]  mode_w     [2];
  logic        bf_w       [2];
  logic [10:0] wr_cnt_w   [2];
  logic [1:0]  wr_mode_w  [2];
  logic        wr_en_w    [2];
  logic        ov_w       [2];
  logic        ol_w       [2];
  logic        busy_w     [2];
  logic        done_w     [2];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  ev_t evq [10][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fft_ctrl #(
      .RD_LAT (g == 0 ? 1 : 2),
      .BF_LAT (g == 0 ? 4 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .ld_we     (ld_we_w[g]),
      .cnt       (cnt_w[g]),
      .mode      (mode_w[g]),
      .bf_valid  (bf_w[g]),
      .wr_cnt    (wr_cnt_w[g]),
      .wr_mode   (wr_mode_w[g]),
      .wr_en     (wr_en_w[g]),
      .out_valid (ov_w[g]),
      .out_last  (ol_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g])
    );
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 5 : 2;
  endfunction

  function automatic int rdl_of(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic ev_t mk(logic [3:0] we, logic [10:0] c,
                             logic [1:0] m, int t);
    ev_t e;
    e.we = we;
    e.cnt = c;
    e.mode = m;
    e.cyc = 32'(t);
    return e;
  endfunction

  function automatic string show(ev_t e);
    return $sformatf("we=%h cnt=%h mode=%h cyc=%0d",
                     e.we, e.cnt, e.mode, e.cyc);
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 10; i++) s += evq[i].size();
    return s;
  endfunction

  // Whole-frame reference: five stages of 256 reads at 0x400 + s*256
  // (mod 2048), each stage followed by LAT idle cycles, then 256 reads.
  function automatic void plan(int d, int p);
    int lat = lat_of(d);
    int t;
    logic [10:0] a;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 256; k++) begin
        t = p + s * (256 + lat) + k;
        a = 11'((1024 + s * 256 + k) % 2048);
        evq[Q_RD*2+d].push_back(mk(4'h0, a, 2'b01, t));
        evq[Q_WR*2+d].push_back(mk(4'h0, a, 2'b01, t + lat));
      end
    end
    t = p + 5 * (256 + lat);
    for (int k = 0; k < 256; k++) begin
      evq[Q_OR*2+d].push_back(mk(4'h0, 11'(k), 2'b11, t + k));
      evq[Q_OV*2+d].push_back(mk((k == 255) ? 4'h3 : 4'h0,
                                 11'd0, 2'b00, t + k + rdl_of(d)));
    end
  endfunction

  task automatic take(int k, int d, string nm, ev_t act);
    ev_t e;
    n_chk++;
    if (evq[k*2+d].size() == 0) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %s, required no event",
               nm, d, show(act));
    end else begin
      e = evq[k*2+d].pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s dut%0d: got %s, required %s",
                 nm, d, show(act), show(e));
      end
    end
  endtask

  task automatic chk(string nm, int d, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, required %h",
               nm, d, act, exp);
    end
  endtask

  task automatic tmo(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d, required event", nm, cyc);
  endtask

  function automatic logic [63:0] outs(int d);
    return 64'({in_ready_w[d], ld_we_w[d], cnt_w[d], mode_w[d],
                bf_w[d], wr_cnt_w[d], wr_mode_w[d], wr_en_w[d],
                ov_w[d], ol_w[d], busy_w[d], done_w[d]});
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          if (ld_we_w[d] != 4'h0)
            take(Q_LD, d, "ld_we",
                 mk(ld_we_w[d], cnt_w[d], mode_w[d], cyc));
          if (bf_w[d])
            take(Q_RD, d, "rd", mk(4'h0, cnt_w[d], mode_w[d], cyc));
          if (wr_en_w[d])
            take(Q_WR, d, "wr",
                 mk(4'h0, wr_cnt_w[d], wr_mode_w[d], cyc));
          if (mode_w[d] == 2'b11)
            take(Q_OR, d, "out_rd",
                 mk(4'h0, cnt_w[d], mode_w[d], cyc));
          if (ov_w[d])
            take(Q_OV, d, "out_valid",
                 mk({2'b00, ol_w[d], done_w[d]},
                    ol_w[d] ? 11'(busy_w[d]) : 11'd0, 2'b00, cyc));
        end
      end
    end
  endtask

  // pace: 0 toggling, 1 random, 2 continuous
  task automatic load_frame(int pace, int hold);
    int n [2];
    int g;
    logic v;
    n[0] = 0;
    n[1] = 0;
    g = 0;
    while (!(in_ready_w[0] && in_ready_w[1] &&
             !busy_w[0] && !busy_w[1]) && g < 4000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 4000) tmo("ready");
    g = 0;
    while ((n[0] < 1024 || n[1] < 1024) && g < 8000) begin
      @(posedge clk); #1;
      g++;
      if (pace == 0) v = g[0];
      else if (pace == 1) v = ($urandom_range(0, 3) != 0);
      else v = 1'b1;
      in_valid = v;
      for (int d = 0; d < 2; d++) begin
        if (v && in_ready_w[d] && n[d] < 1024) begin
          evq[Q_LD*2+d].push_back(
            mk(4'(1 << (n[d] / 256)), 11'(n[d]), 2'b00, cyc));
          if (n[d] == 1023) plan(d, cyc + 1);
          n[d]++;
        end
      end
    end
    if (g >= 8000) tmo("load");
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (hold != 0) begin
      in_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (pending() != 0 && g < 4000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("pending", 0, 64'(pending()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      monitor();
      begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
      end
    join_none

    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("reset_outs", d, outs(d), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    load_frame(0, 0);
    wait_drain();

    load_frame(1, 200);
    wait_drain();

    load_frame(2, 0);
    begin
      int g = 0;
      while (!(cnt_w[0] == 11'h523 && bf_w[0]) && g < 3000) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 3000) tmo("cnt_523");
    end
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) evq[i].delete();
    #1;
    for (int d = 0; d < 2; d++) chk("abort_outs", d, outs(d), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("held_outs", d, outs(d), 64'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    load_frame(2, 0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

- Sequencing controller for the 1024-point radix-4 in-place FFT.
- Drives the 11-bit `cnt` and 2-bit `mode` that feed the four-bank (A/B/C/D, 256 words each) address generator, on both the read side and a delayed write-back side.
- Sequence: load 1024 samples, run five butterfly stages with drain gaps, then stream the digit-reversed result.
- Sits between the sample source, the bank memories/butterfly datapath, and the output consumer.

## Interface
Parameters:
- `RD_LAT`, 1: bank read latency in cycles (≥1).
- `BF_LAT`, 4: butterfly pipeline latency in cycles (≥0).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample present this cycle.
- `in_ready`  out  1  controller accepts samples (IDLE, LOAD).
- `ld_we`  out  4  one-hot bank write enable for the loaded sample: bit `cnt[9:8]` set when `in_valid & in_ready`.
- `cnt`  out  11  read-side count to the address generator.
- `mode`  out  2  read-side mode: 00 load, 01 compute, 11 output.
- `bf_valid`  out  1  read issued for a butterfly this cycle.
- `wr_cnt`  out  11  `cnt` delayed by LAT = RD_LAT+BF_LAT.
- `wr_mode`  out  2  `mode` delayed by LAT.
- `wr_en`  out  1  `bf_valid` delayed by LAT; bank write-back enable.
- `out_valid`  out  1  result read data valid (OUT reads delayed by RD_LAT).
- `out_last`  out  1  with final `out_valid`.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse, coincident with `out_last`.

## Operation
- States: IDLE, LOAD, COMP, DRAIN, OUT. A stage register `stg` counts 0..4.
- **IDLE:** `cnt`=0, `mode`=00, `in_ready`=1. On an accepted sample, `ld_we` is asserted for bank 0 address 0, `cnt`←1, and the state moves to LOAD.
- **LOAD:**
  - `in_ready`=1, `mode`=00.
  - Each accepted sample n is written to bank `n[9:8]`, address `n[7:0]`, and `cnt` increments.
  - Cycles with `in_valid`=0 hold `cnt`.
  - On accepting sample 1023: `cnt`←0x400, `stg`←0, go to COMP.
- **COMP:**
  - `mode`=01, `bf_valid`=1, `cnt` increments every cycle.
  - ST1..ST4 use 0x400–0x7FF. ST5 uses 0x000–0x0FF, reached by natural 11-bit wrap of 0x7FF+1.
  - When `cnt[7:0]`==0xFF, go to DRAIN with `cnt` held.
- **DRAIN:**
  - Lasts exactly LAT cycles. `mode`=01, `bf_valid`=0, `cnt` held.
  - On exit with `stg`<4: `stg`++, `cnt`++, go to COMP.
  - On exit with `stg`==4: `cnt`←0, `mode`←11, go to OUT.
- **OUT:** `mode`=11, `cnt` counts 0..255, one read per cycle. After issuing 255, go to IDLE with `cnt`←0.
- **Write-back pipeline:** {`cnt`,`mode`,`bf_valid`} pass through a LAT-deep delay line, producing `wr_cnt`/`wr_mode`/`wr_en`. It runs in every state.
- **Output pipeline:** (state==OUT) and (`cnt`==255) pass through an RD_LAT-deep delay line, producing `out_valid` and `out_last`. `done` = `out_last`.
- **Input during OUT, COMP or DRAIN:** `in_ready`=0, so `in_valid` is ignored.
- **Back-to-back frames:** the controller returns to IDLE while `out_valid` may still be high for RD_LAT cycles. A new frame may start immediately; its load writes never conflict because OUT reads have all been issued.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, and both delay lines are cleared, asynchronously on `rst_n` low. Reset mid-operation aborts the frame with no further `wr_en`/`out_valid`.
- **Read/write ordering:** the last stage read at cycle T writes back at T+LAT, the final DRAIN cycle. The next stage's first read is at T+LAT+1.
- **Frame length after the last accepted sample:** 5·(256+LAT) cycles of compute, then 256 OUT cycles. `done` follows at +RD_LAT.
- **BF_LAT=0:** DRAIN is RD_LAT cycles and still mandatory.
- **Registered outputs:** every output except `ld_we` and `done` comes from a register or delay-line stage. `ld_we` is combinational from `in_valid` and the state. `done` equals `out_last` and is therefore registered.

## Structure
- **Shared package `fft_pkg`:**
  - State enum.
  - `MODE_LOAD`=2'b00, `MODE_COMP`=2'b01, `MODE_OUT`=2'b11.
  - `FFT_N`=1024, `FFT_STAGES`=5, `BANK_DEPTH`=256, `CNT_W`=11.
- **Sub-module `dly_line`:** parameterised WIDTH/DEPTH shift register with async active-low clear. It is instantiated twice: once for write-back, once for output. DEPTH=0 means a pass-through.

## Test plan
- **Load pacing:** drive 1024 samples with `in_valid` toggling 1/0.
  - Expect `ld_we`=4'b0001 for n=0..255 and 4'b1000 for n=768..1023.
  - Expect `cnt` to hold on idle cycles and COMP to start with `cnt`=0x400.
- **Stage sequence, defaults (LAT=5):**
  - Read-side `cnt` sequence: 0x400..0x4FF, then 5 held cycles, then 0x500…0x7FF.
  - ST5 follows at 0x000..0x0FF.
  - Total COMP+DRAIN = 1305 cycles.
- **Write-back alignment:** `wr_cnt`/`wr_en` equal `cnt`/`bf_valid` shifted by exactly 5 cycles. The last `wr_en` of each stage precedes the next stage's first `bf_valid` by one cycle.
- **Output:**
  - `mode`=11 and `cnt` runs 0..255.
  - `out_valid` is high for 256 consecutive cycles starting 1 cycle later.
  - `out_last` and `done` occur on the 256th cycle.
  - `busy` drops after `cnt`=255.
- **Reset mid-COMP:** assert `rst_n`=0 at `cnt`=0x523.
  - All outputs go to 0 immediately, with no `wr_en` afterwards.
  - A fresh frame completes normally.
- **Parameter corners:** with RD_LAT=2, BF_LAT=0, DRAIN is 2 cycles and `out_valid` lags OUT reads by 2. Also `in_valid` held high during COMP → no `ld_we`.
